// File: rtl/pcie_7x_v1_11_0_drp_arb.sv
// Round-robin owner arbiter and one-deep sequencer sharing a single GT DRP port.
// Define PCIE_DRP_ARB_TIMEOUT_EN to add the DRP_RDY watchdog (DRAIN path, DRP_TIMEOUT).
module pcie_7x_v1_11_0_drp_arb #(
    parameter int unsigned NUM_REQ     = 4,
    parameter logic [15:0] TIMEOUT_MAX = 16'd1023
) (
    input  logic                  DRP_CLK,
    input  logic                  DRP_RST,
    input  logic [NUM_REQ-1:0]    REQ,
    input  logic [NUM_REQ-1:0]    REQ_EN,
    input  logic [NUM_REQ-1:0]    REQ_WE,
    input  logic [NUM_REQ*8-1:0]  REQ_ADDR,
    input  logic [NUM_REQ*16-1:0] REQ_DI,
    output logic [NUM_REQ-1:0]    GNT,
    output logic [NUM_REQ-1:0]    REQ_RDY,
    output logic [15:0]           REQ_DO,
    input  logic [15:0]           DRP_DO,
    input  logic                  DRP_RDY,
    output logic [7:0]            DRP_ADDR,
    output logic                  DRP_EN,
    output logic [15:0]           DRP_DI,
    output logic                  DRP_WE,
    output logic                  DRP_TIMEOUT,
    output logic [3:0]            DRP_FSM
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [3:0] {
        StIdle  = 4'b0001,
        StOwn   = 4'b0010,
        StBusy  = 4'b0100,
        StDrain = 4'b1000
    } state_e;

    state_e        state_q;
    logic [IW-1:0] gnt_idx_q;
    logic [IW-1:0] rr_ptr_q;
    logic [IW-1:0] winner;
    logic [IW-1:0] next_ptr;
    logic          any_req;
    int            scan_idx;

    // First set REQ bit scanning upward from the round-robin pointer, wrapping.
    always_comb begin
        winner   = '0;
        any_req  = 1'b0;
        scan_idx = 0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            scan_idx = int'(rr_ptr_q) + i;
            if (scan_idx >= int'(NUM_REQ)) scan_idx = scan_idx - int'(NUM_REQ);
            if (!any_req && REQ[scan_idx]) begin
                any_req = 1'b1;
                winner  = IW'(scan_idx);
            end
        end
    end

    assign next_ptr = (gnt_idx_q == IW'(NUM_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;
    assign DRP_FSM  = state_q;

`ifdef PCIE_DRP_ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;
    logic        timeout_q;
    assign DRP_TIMEOUT = timeout_q;
`else
    logic unused_tmo;
    assign unused_tmo  = ^TIMEOUT_MAX;
    assign DRP_TIMEOUT = 1'b0;
`endif

    always_ff @(posedge DRP_CLK) begin
        if (DRP_RST) begin
            state_q   <= StIdle;
            gnt_idx_q <= '0;
            rr_ptr_q  <= '0;
            GNT       <= '0;
            REQ_RDY   <= '0;
            REQ_DO    <= '0;
            DRP_EN    <= 1'b0;
            DRP_WE    <= 1'b0;
            DRP_ADDR  <= '0;
            DRP_DI    <= '0;
`ifdef PCIE_DRP_ARB_TIMEOUT_EN
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            REQ_RDY <= '0;
            DRP_EN  <= 1'b0;
            DRP_WE  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (any_req) begin
                        GNT       <= {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
                        gnt_idx_q <= winner;
                        state_q   <= StOwn;
                    end
                end
                StOwn: begin
                    // A strobe beats a simultaneous release; release is taken after RDY.
                    if (REQ_EN[gnt_idx_q]) begin
                        DRP_EN   <= 1'b1;
                        DRP_WE   <= REQ_WE[gnt_idx_q];
                        DRP_ADDR <= REQ_ADDR[8*gnt_idx_q +: 8];
                        DRP_DI   <= REQ_DI[16*gnt_idx_q +: 16];
                        state_q  <= StBusy;
`ifdef PCIE_DRP_ARB_TIMEOUT_EN
                        tmo_cnt_q <= '0;
`endif
                    end else if (!REQ[gnt_idx_q]) begin
                        GNT      <= '0;
                        rr_ptr_q <= next_ptr;
                        state_q  <= StIdle;
                    end
                end
                StBusy: begin
                    if (DRP_RDY) begin
                        REQ_RDY <= GNT;
                        REQ_DO  <= DRP_DO;
                        if (REQ[gnt_idx_q]) begin
                            state_q <= StOwn;
                        end else begin
                            GNT      <= '0;
                            rr_ptr_q <= next_ptr;
                            state_q  <= StIdle;
                        end
                    end
`ifdef PCIE_DRP_ARB_TIMEOUT_EN
                    else if (tmo_cnt_q == TIMEOUT_MAX) begin
                        timeout_q <= 1'b1;
                        state_q   <= StDrain;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 16'd1;
                    end
`endif
                end
`ifdef PCIE_DRP_ARB_TIMEOUT_EN
                StDrain: begin
                    REQ_RDY <= GNT;
                    REQ_DO  <= 16'hFFFF;
                    if (REQ[gnt_idx_q]) begin
                        state_q <= StOwn;
                    end else begin
                        GNT      <= '0;
                        rr_ptr_q <= next_ptr;
                        state_q  <= StIdle;
                    end
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_pcie_7x_v1_11_0_drp_arb.sv
// Directed self-checking bench for the DRP round-robin arbiter (NUM_REQ=4).
module tb_pcie_7x_v1_11_0_drp_arb;

    logic        DRP_CLK;
    logic        DRP_RST;
    logic [3:0]  REQ, REQ_EN, REQ_WE;
    logic [31:0] REQ_ADDR;
    logic [63:0] REQ_DI;
    logic [3:0]  GNT, REQ_RDY;
    logic [15:0] REQ_DO, DRP_DO, DRP_DI;
    logic        DRP_RDY, DRP_EN, DRP_WE, DRP_TIMEOUT;
    logic [7:0]  DRP_ADDR;
    logic [3:0]  DRP_FSM;

    int passed = 0;
    int total  = 0;
    int en_cnt = 0;
    int rdy_cnt = 0;

    pcie_7x_v1_11_0_drp_arb #(
        .NUM_REQ     (4),
        .TIMEOUT_MAX (16'd8)
    ) dut (
        .DRP_CLK     (DRP_CLK),
        .DRP_RST     (DRP_RST),
        .REQ         (REQ),
        .REQ_EN      (REQ_EN),
        .REQ_WE      (REQ_WE),
        .REQ_ADDR    (REQ_ADDR),
        .REQ_DI      (REQ_DI),
        .GNT         (GNT),
        .REQ_RDY     (REQ_RDY),
        .REQ_DO      (REQ_DO),
        .DRP_DO      (DRP_DO),
        .DRP_RDY     (DRP_RDY),
        .DRP_ADDR    (DRP_ADDR),
        .DRP_EN      (DRP_EN),
        .DRP_DI      (DRP_DI),
        .DRP_WE      (DRP_WE),
        .DRP_TIMEOUT (DRP_TIMEOUT),
        .DRP_FSM     (DRP_FSM)
    );

    initial DRP_CLK = 1'b0;
    always #5 DRP_CLK = ~DRP_CLK;

    always @(negedge DRP_CLK) begin
        if (DRP_EN) en_cnt <= en_cnt + 1;
        if (REQ_RDY != 4'b0000) rdy_cnt <= rdy_cnt + 1;
    end

    task automatic tick();
        @(posedge DRP_CLK);
        #1;
    endtask

    task automatic test_reset();
        DRP_RST = 1'b1;
        tick();
        tick();
        total++; if (GNT !== 4'b0000) $display("FAIL rst_gnt: got %b want 0000", GNT); else passed++;
        total++; if (DRP_FSM !== 4'b0001) $display("FAIL rst_fsm: got %b want 0001", DRP_FSM); else passed++;
        total++; if ({DRP_EN, DRP_WE, DRP_ADDR, DRP_DI, REQ_DO, REQ_RDY, DRP_TIMEOUT} !== '0)
            $display("FAIL rst_outs: en=%b we=%b addr=%h di=%h do=%h rdy=%b to=%b want all zero",
                     DRP_EN, DRP_WE, DRP_ADDR, DRP_DI, REQ_DO, REQ_RDY, DRP_TIMEOUT);
        else passed++;
        DRP_RST = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        REQ = 4'b0010;
        tick();
        total++; if (GNT !== 4'b0010) $display("FAIL rd_gnt: got %b want 0010", GNT); else passed++;
        REQ_EN = 4'b0010; REQ_WE = 4'b0000; REQ_ADDR[15:8] = 8'h36;
        tick();
        REQ_EN = 4'b0000;
        total++; if (DRP_EN !== 1'b1 || DRP_ADDR !== 8'h36 || DRP_WE !== 1'b0)
            $display("FAIL rd_drp: en=%b addr=%h we=%b want en=1 addr=36 we=0", DRP_EN, DRP_ADDR, DRP_WE);
        else passed++;
        tick();
        total++; if (DRP_EN !== 1'b0 || DRP_FSM !== 4'b0100)
            $display("FAIL rd_en_pulse: en=%b fsm=%b want en=0 fsm=0100", DRP_EN, DRP_FSM);
        else passed++;
        tick(); tick(); tick();
        DRP_RDY = 1'b1; DRP_DO = 16'h1234;
        tick();
        DRP_RDY = 1'b0; DRP_DO = 16'h0000;
        total++; if (REQ_RDY !== 4'b0010 || REQ_DO !== 16'h1234)
            $display("FAIL rd_rdy: rdy=%b do=%h want rdy=0010 do=1234", REQ_RDY, REQ_DO);
        else passed++;
        tick();
        total++; if (REQ_RDY !== 4'b0000) $display("FAIL rd_rdy_pulse: got %b want 0000", REQ_RDY); else passed++;
        REQ = 4'b0000;
        tick();
        total++; if (GNT !== 4'b0000 || DRP_FSM !== 4'b0001)
            $display("FAIL rd_release: gnt=%b fsm=%b want 0000/0001", GNT, DRP_FSM);
        else passed++;
    endtask

    task automatic test_rmw_hold();
        REQ = 4'b0001;
        tick();
        total++; if (GNT !== 4'b0001) $display("FAIL rmw_gnt: got %b want 0001", GNT); else passed++;
        REQ = 4'b0101;
        REQ_EN = 4'b0001; REQ_WE = 4'b0000; REQ_ADDR[7:0] = 8'h31;
        tick();
        REQ_EN = 4'b0000;
        total++; if (DRP_EN !== 1'b1 || DRP_ADDR !== 8'h31)
            $display("FAIL rmw_rd_drp: en=%b addr=%h want 1/31", DRP_EN, DRP_ADDR);
        else passed++;
        tick();
        DRP_RDY = 1'b1; DRP_DO = 16'h4800;
        tick();
        DRP_RDY = 1'b0;
        total++; if (REQ_RDY !== 4'b0001 || REQ_DO !== 16'h4800 || GNT !== 4'b0001)
            $display("FAIL rmw_rd_rdy: rdy=%b do=%h gnt=%b want 0001/4800/0001", REQ_RDY, REQ_DO, GNT);
        else passed++;
        REQ_EN = 4'b0001; REQ_WE = 4'b0001; REQ_DI[15:0] = 16'h6800;
        tick();
        REQ_EN = 4'b0000; REQ_WE = 4'b0000;
        total++; if (DRP_EN !== 1'b1 || DRP_WE !== 1'b1 || DRP_DI !== 16'h6800 || DRP_ADDR !== 8'h31)
            $display("FAIL rmw_wr_drp: en=%b we=%b di=%h addr=%h want 1/1/6800/31",
                     DRP_EN, DRP_WE, DRP_DI, DRP_ADDR);
        else passed++;
        tick();
        total++; if (DRP_WE !== 1'b0 || GNT !== 4'b0001)
            $display("FAIL rmw_busy: we=%b gnt=%b want 0/0001", DRP_WE, GNT);
        else passed++;
        DRP_RDY = 1'b1; DRP_DO = 16'h6800;
        tick();
        DRP_RDY = 1'b0; DRP_DO = 16'h0000;
        total++; if (REQ_RDY !== 4'b0001 || REQ_DO !== 16'h6800 || GNT !== 4'b0001)
            $display("FAIL rmw_wr_rdy: rdy=%b do=%h gnt=%b want 0001/6800/0001", REQ_RDY, REQ_DO, GNT);
        else passed++;
        REQ = 4'b0100;
        tick();
        total++; if (GNT !== 4'b0000) $display("FAIL rmw_gap: got %b want 0000", GNT); else passed++;
        tick();
        total++; if (GNT !== 4'b0100) $display("FAIL rmw_handover: got %b want 0100", GNT); else passed++;
        REQ = 4'b0000;
        tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt;
        DRP_RST = 1'b1;
        tick();
        DRP_RST = 1'b0;
        REQ = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_gnt = 4'b0001 << (k % 4);
            tick();
            total++; if (GNT !== exp_gnt) $display("FAIL rr_gnt%0d: got %b want %b", k, GNT, exp_gnt); else passed++;
            REQ_EN = exp_gnt;
            tick();
            REQ_EN = 4'b0000;
            DRP_RDY = 1'b1; DRP_DO = 16'(k);
            tick();
            DRP_RDY = 1'b0;
            REQ = 4'b1111 & ~exp_gnt;
            tick();
            REQ = 4'b1111;
        end
        REQ = 4'b0000;
        tick();
    endtask

    task automatic test_illegal_strobes();
        int en0, rdy0;
        REQ = 4'b0010;
        tick();
        total++; if (GNT !== 4'b0010) $display("FAIL ill_gnt: got %b want 0010", GNT); else passed++;
        en0 = en_cnt; rdy0 = rdy_cnt;
        REQ_EN = 4'b1000;
        tick();
        total++; if (DRP_EN !== 1'b0 || DRP_FSM !== 4'b0010)
            $display("FAIL ill_foreign: en=%b fsm=%b want 0/0010", DRP_EN, DRP_FSM);
        else passed++;
        REQ_EN = 4'b0010;
        tick();
        REQ_EN = 4'b1010;
        tick();
        REQ_EN = 4'b0010;
        tick();
        REQ_EN = 4'b0000;
        total++; if (DRP_EN !== 1'b0 || DRP_FSM !== 4'b0100)
            $display("FAIL ill_busy: en=%b fsm=%b want 0/0100", DRP_EN, DRP_FSM);
        else passed++;
        DRP_RDY = 1'b1; DRP_DO = 16'hBEEF;
        tick();
        DRP_RDY = 1'b0;
        tick();
        tick();
        total++; if (en_cnt - en0 !== 1) $display("FAIL ill_en_count: got %0d want 1", en_cnt - en0); else passed++;
        total++; if (rdy_cnt - rdy0 !== 1) $display("FAIL ill_rdy_count: got %0d want 1", rdy_cnt - rdy0); else passed++;
        DRP_RDY = 1'b1;
        tick();
        DRP_RDY = 1'b0;
        total++; if (REQ_RDY !== 4'b0000 || DRP_FSM !== 4'b0010)
            $display("FAIL ill_stray_rdy: rdy=%b fsm=%b want 0000/0010", REQ_RDY, DRP_FSM);
        else passed++;
        REQ = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid_busy();
        REQ = 4'b0100;
        tick();
        REQ_EN = 4'b0100; REQ_WE = 4'b0100; REQ_ADDR[23:16] = 8'h5A; REQ_DI[47:32] = 16'hA5A5;
        tick();
        REQ_EN = 4'b0000; REQ_WE = 4'b0000;
        total++; if (DRP_EN !== 1'b1) $display("FAIL rb_en: got %b want 1", DRP_EN); else passed++;
        DRP_RST = 1'b1; DRP_RDY = 1'b1; DRP_DO = 16'h7777;
        tick();
        DRP_RST = 1'b0; DRP_RDY = 1'b0; REQ = 4'b0000;
        total++; if ({GNT, REQ_RDY, REQ_DO, DRP_EN, DRP_WE, DRP_ADDR, DRP_DI, DRP_TIMEOUT} !== '0
                     || DRP_FSM !== 4'b0001)
            $display("FAIL rb_outs: gnt=%b rdy=%b do=%h en=%b we=%b addr=%h di=%h fsm=%b want zeros, fsm 0001",
                     GNT, REQ_RDY, REQ_DO, DRP_EN, DRP_WE, DRP_ADDR, DRP_DI, DRP_FSM);
        else passed++;
        tick();
        total++; if (REQ_RDY !== 4'b0000) $display("FAIL rb_no_rdy: got %b want 0000", REQ_RDY); else passed++;
        REQ = 4'b1010;
        tick();
        total++; if (GNT !== 4'b0010) $display("FAIL rb_ptr0: got %b want 0010", GNT); else passed++;
        REQ = 4'b0000;
        tick();
    endtask

    task automatic test_timeout();
        int rdy0;
        bit seen;
        REQ = 4'b0001;
        tick();
        REQ_EN = 4'b0001;
        tick();
        REQ_EN = 4'b0000;
        rdy0 = rdy_cnt;
        seen = 1'b0;
`ifdef PCIE_DRP_ARB_TIMEOUT_EN
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (REQ_RDY != 4'b0000) seen = 1'b1;
        end
        total++; if (!seen) $display("FAIL to_rdy: no REQ_RDY within 40 cycles, want pulse"); else passed++;
        total++; if (REQ_RDY !== 4'b0001 || REQ_DO !== 16'hFFFF || DRP_TIMEOUT !== 1'b1)
            $display("FAIL to_result: rdy=%b do=%h to=%b want 0001/ffff/1", REQ_RDY, REQ_DO, DRP_TIMEOUT);
        else passed++;
`else
        for (int i = 0; i < 40; i++) tick();
        total++; if (DRP_FSM !== 4'b0100 || DRP_TIMEOUT !== 1'b0 || rdy_cnt != rdy0)
            $display("FAIL to_wait: fsm=%b to=%b rdy_pulses=%0d want 0100/0/0",
                     DRP_FSM, DRP_TIMEOUT, rdy_cnt - rdy0);
        else passed++;
        DRP_RDY = 1'b1; DRP_DO = 16'h0F0F;
        tick();
        DRP_RDY = 1'b0;
        total++; if (REQ_RDY !== 4'b0001 || REQ_DO !== 16'h0F0F)
            $display("FAIL to_late_rdy: rdy=%b do=%h want 0001/0f0f", REQ_RDY, REQ_DO);
        else passed++;
`endif
        REQ = 4'b0000;
        tick();
        tick();
    endtask

    initial begin
        DRP_RST = 1'b1; REQ = '0; REQ_EN = '0; REQ_WE = '0; REQ_ADDR = '0; REQ_DI = '0;
        DRP_RDY = 1'b0; DRP_DO = '0;
        test_reset();
        test_single_read();
        test_rmw_hold();
        test_round_robin();
        test_illegal_strobes();
        test_reset_mid_busy();
        test_timeout();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
